sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 99 +++++++++
 tb/tb_sipo_deserializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: collects WIDTH bits MSB first and holds
// each completed word behind a valid/ready handshake with a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift,
  input  logic                     serial_in,
  input  logic                     clear,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic S_EMPTY = 1'b0;
  localparam logic S_FULL  = 1'b1;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    count_q, count_d;
  logic             state_q, state_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             consume;

  assign shifted  = {sr_q[WIDTH-2:0], serial_in};
  assign complete = shift && (count_q == LAST_BIT);
  // out_ready only matters while a word is actually held.
  assign consume  = (state_q == S_FULL) && out_ready;

  // NOTE: every next-state variable gets a default first so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    sr_d      = sr_q;
    word_d    = word_q;
    count_d   = count_q;
    state_d   = state_q;
    overrun_d = overrun_q;

    if (clear) begin
      sr_d      = '0;
      count_d   = '0;
      state_d   = S_EMPTY;
      overrun_d = 1'b0;
    end else begin
      if (shift) begin
        sr_d = shifted;
        if (complete) begin
          count_d = '0;
          word_d  = shifted;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      if (complete) begin
        state_d = S_FULL;
        // A held word lost without being consumed; a same-edge consume is safe.
        if ((state_q == S_FULL) && !out_ready) begin
          overrun_d = 1'b1;
        end
      end else if (consume) begin
        state_d = S_EMPTY;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q      <= '0;
      word_q    <= '0;
      count_q   <= '0;
      state_q   <= S_EMPTY;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      word_q    <= word_d;
      count_q   <= count_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = word_q;
  assign out_valid    = (state_q == S_FULL);
  assign overrun      = overrun_q;
  assign bit_count    = count_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (WIDTH=4): directed words with a scoreboard
// queue of expected presentations and a monitor that pops on each new word.
module tb_sipo_deserializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             shift = 1'b0;
  logic             ser_bit = 1'b0;
  logic             serial_in;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             overrun;
  logic [1:0]       bit_count;

  // Small PISO used for the loopback case.
  logic [3:0] piso_q = 4'h0;
  logic       piso_load = 1'b0;
  logic [3:0] piso_val = 4'h0;
  logic       piso_shift = 1'b0;
  logic       loopback = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             ovr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (piso_load) piso_q <= piso_val;
    else if (piso_shift) piso_q <= {piso_q[2:0], 1'b0};
  end

  assign serial_in = loopback ? piso_q[3] : ser_bit;

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .shift        (shift),
    .serial_in    (serial_in),
    .clear        (clear),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .bit_count    (bit_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b, input logic rdy);
    shift     = 1'b1;
    ser_bit   = b;
    out_ready = rdy;
    tick();
    shift     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] w, input logic o);
    exp_t e;
    e.word = w;
    e.ovr  = o;
    exp_q.push_back(e);
  endtask

  // Monitor: a new presentation is out_valid rising or the held word changing.
  logic             prev_valid = 1'b0;
  logic [WIDTH-1:0] prev_word = '0;
  always @(negedge clk) begin
    if (reset && out_valid && (!prev_valid || parallel_out != prev_word)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {28'h0, parallel_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_word", {28'h0, parallel_out}, {28'h0, e.word});
        check("sb_overrun", {31'h0, overrun}, {31'h0, e.ovr});
      end
    end
    prev_valid = reset ? out_valid : 1'b0;
    prev_word  = parallel_out;
  end

  initial begin
    // Reset state
    #12;
    check("rst_word", {28'h0, parallel_out}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_count", {30'h0, bit_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic word 1,0,1,1 -> B
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    push_exp(4'hB, 1'b0);
    check("basic_count", {30'h0, bit_count}, 32'h0);
    tick();

    // Overrun: 0,1,1,0 while B held and not consumed -> 6 with overrun
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    push_exp(4'h6, 1'b1);
    tick();

    // Clear pulse keeps the word but drops valid and overrun
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", {31'h0, out_valid}, 32'h0);
    check("clr_overrun", {31'h0, overrun}, 32'h0);
    check("clr_word", {28'h0, parallel_out}, 32'h6);

    // Gapped shifting: count advances only on shift edges
    shift_bit(1'b1, 1'b0);
    check("gap_count1", {30'h0, bit_count}, 32'h1);
    tick(); tick();
    check("gap_idle", {30'h0, bit_count}, 32'h1);
    shift_bit(1'b0, 1'b0);
    check("gap_count2", {30'h0, bit_count}, 32'h2);
    tick();
    shift_bit(1'b1, 1'b0);
    check("gap_count3", {30'h0, bit_count}, 32'h3);
    tick(); tick();
    shift_bit(1'b1, 1'b0);
    push_exp(4'hB, 1'b0);
    tick();

    // Consume and completion on the same edge -> F, no overrun
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b1);
    push_exp(4'hF, 1'b0);
    check("simul_valid", {31'h0, out_valid}, 32'h1);
    tick();

    // Plain consume, then out_ready while empty is harmless
    out_ready = 1'b1;
    tick();
    check("cons_valid", {31'h0, out_valid}, 32'h0);
    check("cons_word", {28'h0, parallel_out}, 32'hF);
    tick();
    out_ready = 1'b0;
    check("empty_ready", {31'h0, out_valid}, 32'h0);

    // Reset mid-word, asserted between clock edges
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("amid_word", {28'h0, parallel_out}, 32'h0);
    check("amid_valid", {31'h0, out_valid}, 32'h0);
    check("amid_overrun", {31'h0, overrun}, 32'h0);
    check("amid_count", {30'h0, bit_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    push_exp(4'h3, 1'b0);
    tick();

    // Clear wins over shift and out_ready mid-word
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    clear     = 1'b1;
    shift     = 1'b1;
    ser_bit   = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    shift     = 1'b0;
    out_ready = 1'b0;
    check("clrpri_count", {30'h0, bit_count}, 32'h0);
    check("clrpri_valid", {31'h0, out_valid}, 32'h0);
    check("clrpri_word", {28'h0, parallel_out}, 32'h3);

    // Loopback from a PISO loaded with A
    piso_val  = 4'hA;
    piso_load = 1'b1;
    tick();
    piso_load  = 1'b0;
    loopback   = 1'b1;
    piso_shift = 1'b1;
    shift      = 1'b1;
    repeat (4) tick();
    shift      = 1'b0;
    piso_shift = 1'b0;
    loopback   = 1'b0;
    push_exp(4'hA, 1'b0);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
